nmos_piso_unload: RTL

//  Parallel-load, serial-out unload register; the transmit end of the NMOS load-register path.
//  A WIDTH-bit word is captured into a master stage and transferred to a slave stage on PHI1.
//  It then shifts out one bit per PHI1 period, with PHI2 advancing the master stage.

---
 rtl/nmos_pkg.sv | 19 +
 rtl/nmos_piso_unload_ms_bit.sv | 36 +++
 rtl/nmos_piso_unload.sv | 87 ++++++++
 3 files changed

// File: rtl/nmos_pkg.sv
// Shared helpers for the NMOS unload register: counter sizing and
// shift-chain wiring that depends on the serial bit order.
package nmos_pkg;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    // Index of the slave bit that feeds master[i] on a shift, or -1 for zero fill.
    function automatic int shift_src(input int i, input int width, input bit msb_first);
        if (msb_first) return i - 1;
        return (i == width - 1) ? -1 : i + 1;
    endfunction

    function automatic int so_idx(input int width, input bit msb_first);
        return msb_first ? width - 1 : 0;
    endfunction

endpackage

// File: rtl/nmos_piso_unload_ms_bit.sv
// One master/slave cell: the master takes parallel data or a shifted neighbour,
// and the slave copies the master on the PHI1 qualifier.
module nmos_ms_bit (
    input  logic main_clk,
    input  logic R_n,
    input  logic d_i,
    input  logic sin_i,
    input  logic ld_i,
    input  logic shift_en_i,
    input  logic c1_i,
    output logic slave_o
);

    logic master_q, master_d;
    logic slave_q,  slave_d;

    always_comb begin
        master_d = master_q;
        if (ld_i)            master_d = d_i;
        else if (shift_en_i) master_d = sin_i;
        slave_d = c1_i ? master_q : slave_q;
    end

    always_ff @(posedge main_clk or negedge R_n) begin
        if (!R_n) begin
            master_q <= 1'b0;
            slave_q  <= 1'b0;
        end else begin
            master_q <= master_d;
            slave_q  <= slave_d;
        end
    end

    assign slave_o = slave_q;

endmodule

// File: rtl/nmos_piso_unload.sv
// Parallel-load, serial-out unload register with two-phase (PHI1/PHI2) timing
// qualified on a single simulation clock.
module nmos_piso_unload
    import nmos_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             main_clk,
    input  logic             R_n,
    input  logic             C1,
    input  logic             C2,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic             SO,
    output logic             SO_n,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW     = cnt_w(WIDTH);
    localparam int SO_IDX = so_idx(WIDTH, MSB_FIRST != 0);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ld_pend_q, ld_pend_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] slave;
    logic             shift_en;

    // Shifting only while bits remain keeps an idle register frozen at zero.
    assign shift_en = C2 && (cnt_q != '0);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam int SRC = shift_src(i, WIDTH, MSB_FIRST != 0);
        logic sin;
        if (SRC < 0) begin : g_fill
            assign sin = 1'b0;
        end else begin : g_chain
            assign sin = slave[SRC];
        end
        nmos_ms_bit u_cell (
            .main_clk   (main_clk),
            .R_n        (R_n),
            .d_i        (D[i]),
            .sin_i      (sin),
            .ld_i       (LD),
            .shift_en_i (shift_en),
            .c1_i       (C1),
            .slave_o    (slave[i])
        );
    end

    always_comb begin
        cnt_d     = cnt_q;
        ld_pend_d = ld_pend_q;
        done_d    = 1'b0;
        if (C1) begin
            if (ld_pend_q) begin
                cnt_d     = CW'(WIDTH);
                ld_pend_d = 1'b0;
            end else if (cnt_q != '0) begin
                cnt_d  = cnt_q - CW'(1);
                // A load arriving on the final edge aborts the word, so no DONE.
                done_d = (cnt_q == CW'(1)) && !LD;
            end
        end
        if (LD) ld_pend_d = 1'b1;
    end

    always_ff @(posedge main_clk or negedge R_n) begin
        if (!R_n) begin
            cnt_q     <= '0;
            ld_pend_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ld_pend_q <= ld_pend_d;
            done_q    <= done_d;
        end
    end

    assign SO   = slave[SO_IDX];
    assign SO_n = ~slave[SO_IDX];
    assign BUSY = ld_pend_q | (cnt_q != '0);
    assign DONE = done_q;

endmodule
